// File: rtl/pr3_stream_parser.sv
// Receive-side parser for the PR3 phase-result stream: strips antenna-block headers,
// tags payload with sop/eop/num/antenna and checks ordering, continuity and truncation.
module pr3_stream_parser #(
  parameter int NSINK   = 3,
  parameter int NWORDS  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sink_valid,
  input  logic [31:0] sink_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  output logic [23:0] source_num,
  output logic [7:0]  source_antenna,
  output logic [31:0] source_data,
  output logic        frame_done,
  output logic        err_seq,
  output logic        err_antenna,
  output logic        err_trunc,
  output logic [15:0] err_count
);

  localparam int WCW = $clog2(NWORDS + 1);
  localparam int IW  = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WLAST    = WCW'(NWORDS - 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0]  IDLE_HIT = IW'(TIMEOUT - 1);
  localparam logic [7:0]     ANT_LAST = 8'(NSINK - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  state_e         state_q;
  logic           synced_q;
  logic [7:0]     exp_ant_q;
  logic [23:0]    exp_num_q;
  logic [WCW-1:0] wcnt_q;
  logic [IW-1:0]  idle_q, idle_d;
  logic           src_valid_q, src_sop_q, src_eop_q, frame_done_q;
  logic [23:0]    src_num_q;
  logic [7:0]     src_ant_q;
  logic [31:0]    src_data_q;
  logic           err_seq_q, err_ant_q, err_trunc_q;
  logic [15:0]    err_count_q, err_count_d;

  logic [23:0]    hdr_num_s;
  logic [7:0]     hdr_ant_s;
  logic           timeout_s, hdr_s, ant_bad_s, seq_bad_s, trunc_s, last_word_s, err_any_s;

  // Header decode, timeout detection, error classification and counter next-state.
  always_comb begin
    hdr_num_s   = sink_data[31:8];
    hdr_ant_s   = sink_data[7:0];
    // A valid word in the cycle idle would reach TIMEOUT suppresses the timeout.
    timeout_s   = !sink_valid && (idle_q == IDLE_HIT);
    hdr_s       = sink_valid && (state_q == HEADER);
    ant_bad_s   = (hdr_ant_s != exp_ant_q) || (!synced_q && (hdr_ant_s != 8'd0));
    seq_bad_s   = hdr_s && !ant_bad_s && synced_q && (hdr_ant_s == 8'd0) &&
                  (hdr_num_s != exp_num_q);
    trunc_s     = timeout_s && ((state_q == PAYLOAD) ||
                                ((state_q == HEADER) && (exp_ant_q != 8'd0)));
    last_word_s = (wcnt_q == WLAST);
    err_any_s   = (hdr_s && ant_bad_s) || seq_bad_s || trunc_s;

    if (sink_valid) begin
      idle_d = IW'(0);
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IW'(1);
    end else begin
      idle_d = idle_q;
    end

    if (err_any_s && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Parser state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HEADER;
      synced_q     <= 1'b0;
      exp_ant_q    <= 8'd0;
      exp_num_q    <= 24'd0;
      wcnt_q       <= WCW'(0);
      idle_q       <= IW'(0);
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      src_num_q    <= 24'd0;
      src_ant_q    <= 8'd0;
      src_data_q   <= 32'd0;
      frame_done_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_ant_q    <= 1'b0;
      err_trunc_q  <= 1'b0;
      err_count_q  <= 16'd0;
    end else begin
      idle_q       <= idle_d;
      err_count_q  <= err_count_d;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_seq_q    <= seq_bad_s;
      err_ant_q    <= hdr_s && ant_bad_s;
      err_trunc_q  <= trunc_s;
      case (state_q)
        HUNT: begin
          if (timeout_s) begin
            synced_q  <= 1'b0;
            exp_ant_q <= 8'd0;
            state_q   <= HEADER;
          end
        end
        HEADER: begin
          if (sink_valid) begin
            if (ant_bad_s) begin
              state_q <= HUNT;
            end else begin
              src_num_q <= hdr_num_s;
              src_ant_q <= hdr_ant_s;
              wcnt_q    <= WCW'(0);
              state_q   <= PAYLOAD;
              if (hdr_ant_s == 8'd0) begin
                exp_num_q <= hdr_num_s + 24'd1;
                synced_q  <= 1'b1;
              end
            end
          end else if (trunc_s) begin
            synced_q  <= 1'b0;
            exp_ant_q <= 8'd0;
          end
        end
        PAYLOAD: begin
          if (sink_valid) begin
            src_valid_q <= 1'b1;
            src_data_q  <= sink_data;
            src_sop_q   <= (wcnt_q == WCW'(0));
            src_eop_q   <= last_word_s;
            wcnt_q      <= wcnt_q + WCW'(1);
            if (last_word_s) begin
              state_q      <= HEADER;
              frame_done_q <= (exp_ant_q == ANT_LAST);
              exp_ant_q    <= (exp_ant_q == ANT_LAST) ? 8'd0 : exp_ant_q + 8'd1;
            end
          end else if (timeout_s) begin
            synced_q  <= 1'b0;
            exp_ant_q <= 8'd0;
            state_q   <= HEADER;
          end
        end
        default: begin
          state_q <= HEADER;
        end
      endcase
    end
  end

  assign source_valid   = src_valid_q;
  assign source_sop     = src_sop_q;
  assign source_eop     = src_eop_q;
  assign source_num     = src_num_q;
  assign source_antenna = src_ant_q;
  assign source_data    = src_data_q;
  assign frame_done     = frame_done_q;
  assign err_seq        = err_seq_q;
  assign err_antenna    = err_ant_q;
  assign err_trunc      = err_trunc_q;
  assign err_count      = err_count_q;

endmodule
